// File: rtl/fp_pkg.sv
// Shared widths and operand type for the floating-point adder datapath.
package fp_pkg;
  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 24;
  localparam int GRS_W     = 3;

  typedef struct packed {
    logic                 sign;
    logic [EXP_W_DEF-1:0] exp;
    logic [MAN_W_DEF-1:0] man;
  } operand_t;
endpackage

// File: rtl/fp_align_shifter.sv
// Combinational right shifter that ORs every shifted-out bit into bit 0,
// collapsing to a lone sticky bit once the shift covers the whole word.
module fp_align_shifter #(
  parameter int W    = 27,
  parameter int SH_W = 8
) (
  input  logic [W-1:0]    val,
  input  logic [SH_W-1:0] shift,
  output logic [W-1:0]    res
);
  logic [W-1:0] shifted;
  logic [W-1:0] lost_mask;
  logic         sticky;

  always_comb begin
    shifted   = '0;
    lost_mask = '0;
    sticky    = 1'b0;
    res       = '0;
    if (32'(shift) >= 32'(W)) begin
      res = {{(W-1){1'b0}}, |val};
    end else begin
      shifted   = val >> shift;
      lost_mask = ~({W{1'b1}} << shift);
      sticky    = |(val & lost_mask);
      res       = {shifted[W-1:1], shifted[0] | sticky};
    end
  end
endmodule

// File: rtl/fp_align_stage.sv
// Operand alignment for the FP add/sub: stage 1 compares exponents and swaps,
// stage 2 right-shifts the smaller mantissa with guard/round/sticky.
module fp_align_stage
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   sign_a,
  input  logic                   sign_b,
  input  logic [EXP_W-1:0]       exp_a,
  input  logic [EXP_W-1:0]       exp_b,
  input  logic [MAN_W-1:0]       man_a,
  input  logic [MAN_W-1:0]       man_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W-1:0]       out_exp,
  output logic                   out_sign_big,
  output logic                   out_sign_small,
  output logic [MAN_W-1:0]       out_man_big,
  output logic [MAN_W+GRS_W-1:0] out_man_small,
  output logic                   out_swapped,
  output logic [EXP_W-1:0]       out_shift
);
  localparam int SM_W = MAN_W + GRS_W;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } op_t;

  logic             s1_valid;
  op_t              s1_big, s1_small;
  logic             s1_swapped;
  logic [EXP_W-1:0] s1_shift;

  logic             s2_advance, in_fire;
  logic [EXP_W:0]   diff;
  logic             borrow;
  logic [EXP_W-1:0] shift_c;
  op_t              op_a, op_b;
  logic [SM_W-1:0]  aligned;

  assign s2_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s2_advance;
  assign in_fire    = in_valid && in_ready;

  // Borrow out of the widened subtraction says B has the larger exponent.
  assign diff    = {1'b0, exp_a} - {1'b0, exp_b};
  assign borrow  = diff[EXP_W];
  assign shift_c = borrow ? (exp_b - exp_a) : diff[EXP_W-1:0];
  assign op_a    = '{sign: sign_a, exp: exp_a, man: man_a};
  assign op_b    = '{sign: sign_b, exp: exp_b, man: man_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_big     <= '0;
      s1_small   <= '0;
      s1_swapped <= 1'b0;
      s1_shift   <= '0;
    end else if (in_fire) begin
      s1_valid   <= 1'b1;
      s1_big     <= borrow ? op_b : op_a;
      s1_small   <= borrow ? op_a : op_b;
      s1_swapped <= borrow;
      s1_shift   <= shift_c;
    end else if (s2_advance) begin
      s1_valid <= 1'b0;
    end
  end

  fp_align_shifter #(.W(SM_W), .SH_W(EXP_W)) u_shifter (
    .val  ({s1_small.man, {GRS_W{1'b0}}}),
    .shift(s1_shift),
    .res  (aligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_exp        <= '0;
      out_sign_big   <= 1'b0;
      out_sign_small <= 1'b0;
      out_man_big    <= '0;
      out_man_small  <= '0;
      out_swapped    <= 1'b0;
      out_shift      <= '0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_exp        <= s1_big.exp;
        out_sign_big   <= s1_big.sign;
        out_sign_small <= s1_small.sign;
        out_man_big    <= s1_big.man;
        out_man_small  <= aligned;
        out_swapped    <= s1_swapped;
        out_shift      <= s1_shift;
      end
    end
  end
endmodule
